// File: rtl/ether_stat_pkg.sv
// ether_stat_pkg: shared stat-event widths and event record for the data ports, arbiter and stat block
package ether_stat_pkg;
  localparam int STAT_BASE_W = 4;
  localparam int STAT_BIT_W  = 64;
  localparam int STAT_VEC_W  = 576;
  typedef struct packed {
    logic [STAT_BASE_W-1:0] base_addr;
    logic [STAT_BIT_W-1:0]  stat_bit;
    logic [STAT_VEC_W-1:0]  stat_vec;
  } stat_evt_t;
endpackage

// File: rtl/ether_stat_fifo.sv
// ether_stat_fifo: single-clock DEPTH-entry FIFO holding one channel's pending stat events
module ether_stat_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] rdata_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, rp_q;
  assign empty_o = wp_q == rp_q;
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign rdata_o = mem_q[rp_q[AW-1:0]];
  // read/write pointers with wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= push_i ? wp_q + 1'b1 : wp_q;
      rp_q <= pop_i ? rp_q + 1'b1 : rp_q;
    end
  // storage; a full FIFO may be written while popping since the popped slot is read before the edge
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q[AW-1:0]] <= wdata_i;
endmodule

// File: rtl/ether_stat_arb.sv
// ether_stat_arb: round-robin merge of NUM_CH stat event streams; STAT_ARB_DROP_CNT_EN builds drop counters
module ether_stat_arb
  import ether_stat_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int BASE_W = STAT_BASE_W,
  parameter int BIT_W  = STAT_BIT_W,
  parameter int VEC_W  = STAT_VEC_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_chk,
  input  logic [NUM_CH*BASE_W-1:0] in_base_addr,
  input  logic [NUM_CH*BIT_W-1:0]  in_bit,
  input  logic [NUM_CH*VEC_W-1:0]  in_vec,
  output logic                     out_chk,
  output logic [CH_W+BASE_W-1:0]   out_base_addr,
  output logic [BIT_W-1:0]         out_bit,
  output logic [VEC_W-1:0]         out_vec,
  input  logic                     out_rdy,
  input  logic                     ovf_clr,
  output logic [NUM_CH-1:0]        ovf_sticky,
  output logic [NUM_CH*CNT_W-1:0]  drop_cnt
);
  localparam int EW = BASE_W + BIT_W + VEC_W;
  logic [NUM_CH-1:0]      full, empty, push, pop, drop, ovf_q, ovf_d;
  logic [EW-1:0]          rd_data [NUM_CH];
  logic [EW-1:0]          sel;
  logic [CH_W-1:0]        rr_q, rr_d, gnt;
  logic                   any, gnt_v, load;
  logic                   out_chk_q, out_chk_d;
  logic [CH_W+BASE_W-1:0] out_base_q, out_base_d;
  logic [BIT_W-1:0]       out_bit_q, out_bit_d;
  logic [VEC_W-1:0]       out_vec_q, out_vec_d;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign push[i] = in_chk[i] & (~full[i] | pop[i]);
    assign drop[i] = in_chk[i] & full[i] & ~pop[i];
    ether_stat_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .wdata_i ({in_base_addr[i*BASE_W +: BASE_W], in_bit[i*BIT_W +: BIT_W], in_vec[i*VEC_W +: VEC_W]}),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .rdata_o (rd_data[i])
    );
  end
  assign load  = ~out_chk_q | out_rdy;
  assign gnt_v = any & load;
  assign pop   = gnt_v ? NUM_CH'(1) << gnt : '0;
  // first non-empty channel at or after the round-robin pointer; descending scan lets the nearest win
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (!empty[(int'(rr_q) + k) % NUM_CH]) begin
        gnt = CH_W'((int'(rr_q) + k) % NUM_CH);
        any = 1'b1;
      end
  end
  // next-state for pointer, output register and sticky overflow flags (set beats clear)
  always_comb begin
    sel        = rd_data[gnt];
    rr_d       = gnt_v ? (gnt == CH_W'(NUM_CH - 1) ? '0 : gnt + 1'b1) : rr_q;
    out_chk_d  = load ? gnt_v : out_chk_q;
    out_base_d = gnt_v ? {gnt, sel[EW-1 -: BASE_W]} : out_base_q;
    out_bit_d  = gnt_v ? sel[VEC_W +: BIT_W] : out_bit_q;
    out_vec_d  = gnt_v ? sel[VEC_W-1:0] : out_vec_q;
    ovf_d      = (ovf_q & ~{NUM_CH{ovf_clr}}) | drop;
  end
  // state registers; reset discards anything in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_q       <= '0;
      out_chk_q  <= 1'b0;
      out_base_q <= '0;
      out_bit_q  <= '0;
      out_vec_q  <= '0;
      ovf_q      <= '0;
    end else begin
      rr_q       <= rr_d;
      out_chk_q  <= out_chk_d;
      out_base_q <= out_base_d;
      out_bit_q  <= out_bit_d;
      out_vec_q  <= out_vec_d;
      ovf_q      <= ovf_d;
    end
  assign out_chk       = out_chk_q;
  assign out_base_addr = out_base_q;
  assign out_bit       = out_bit_q;
  assign out_vec       = out_vec_q;
  assign ovf_sticky    = ovf_q;
`ifdef STAT_ARB_DROP_CNT_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    // saturating count of events dropped on this channel
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else if (drop[i] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    assign drop_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`else
  assign drop_cnt = '0;
`endif
endmodule
